// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter and load sequencer for a shared register bank
module reg_write_arbiter #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         REQ,
  input  logic [4*WIDTH-1:0] DIN,
  output logic [3:0]         GNT,
  output logic               WE,
  output logic [WIDTH-1:0]   DOUT,
  output logic [3:0]         ACK,
  output logic               BUSY
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] CNT_INIT = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  logic [1:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [3:0]       ack_q, ack_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [1:0]       pick;
  logic [WIDTH-1:0] din_sel;

  // First set request bit searching upward from the pointer, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && REQ[ptr_q + 2'(k)]) begin
        found = 1'b1;
        pick  = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    din_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (pick == 2'(i)) begin
        din_sel = DIN[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LOAD;
          idx_d   = pick;
          gnt_d   = 4'b0001 << pick;
          dout_d  = din_sel;
        end
      end
      S_LOAD: begin
        if (SETTLE == 0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = CNT_INIT;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        ptr_d   = idx_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    we_d   = (state_d == S_LOAD);
    ack_d  = (state_d == S_DONE) ? gnt_d : 4'b0000;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 4'b0000;
      we_q    <= 1'b0;
      dout_q  <= '0;
      ack_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT  = gnt_q;
  assign WE   = we_q;
  assign DOUT = dout_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;

endmodule
